// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: issues one req/gnt(/rvalid) bus transaction per
// aligned memory instruction, stalls the core meanwhile and returns lane-aligned load data.
module lsu_bus_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] eff_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic [DATA_W-1:0] rddata,
    output logic              misaligned_exc,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [1:0]        dbg_state
);

    // Bus handshake: bus_req stays high with stable addr/we/be/wdata until the
    // cycle bus_gnt is sampled high; for reads the data arrives later on the
    // cycle bus_rvalid is sampled high. gnt/rvalid outside those phases are ignored.

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       offset;
    logic [CNT_W-1:0] cnt;

    logic              is_b;
    logic              is_h;
    logic              access;
    logic              misalign;
    logic              start;
    logic              timeout;
    logic [3:0]        be_next;
    logic [DATA_W-1:0] wdata_next;

    always_comb begin
        is_b = 1'b0;
        is_h = 1'b0;
        case (funct3)
            3'b000, 3'b100: is_b = 1'b1;
            3'b001, 3'b101: is_h = 1'b1;
            default:        ;
        endcase
    end

    assign access   = mem_rd | mem_wr;
    assign misalign = is_h ? eff_addr[0] : (!is_b && (eff_addr[1:0] != 2'b00));
    assign start    = (state == IDLE) && access && !misalign;
    assign timeout  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Stall is forced low during reset so an abandoned access cannot freeze the core.
    assign stall     = rst_n && (start || state == REQ || state == WAIT_RD);
    assign dbg_state = state;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = '0;
        if (mem_wr) begin
            wdata_next = store_data;
            if (is_b) begin
                be_next    = 4'b0001 << eff_addr[1:0];
                wdata_next = {4{store_data[7:0]}};
            end else if (is_h) begin
                be_next    = 4'b0011 << eff_addr[1:0];
                wdata_next = {2{store_data[15:0]}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            offset         <= 2'b00;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_be         <= 4'b0000;
            bus_wdata      <= '0;
            rddata         <= '0;
            bus_err        <= 1'b0;
            misaligned_exc <= 1'b0;
        end else begin
            misaligned_exc <= 1'b0;
            bus_err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (misalign) begin
                            misaligned_exc <= 1'b1;
                        end else begin
                            bus_addr  <= {eff_addr[ADDR_W-1:2], 2'b00};
                            bus_we    <= mem_wr;
                            bus_be    <= be_next;
                            bus_wdata <= wdata_next;
                            offset    <= eff_addr[1:0];
                            bus_req   <= 1'b1;
                            cnt       <= '0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        state   <= bus_we ? DONE : WAIT_RD;
                    end else if (timeout) begin
                        bus_req <= 1'b0;
                        rddata  <= '0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_RD: begin
                    if (bus_rvalid) begin
                        rddata <= bus_rdata >> {offset, 3'b000};
                        state  <= DONE;
                    end else if (timeout) begin
                        rddata  <= '0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // DONE: one non-stalled cycle so the instruction retires.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed cases plus randomized accesses
// with random bus delays, checked against a transaction-level model.
module tb_lsu_bus_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd, mem_wr;
    logic [2:0]  funct3;
    logic [31:0] eff_addr, store_data;
    logic        stall;
    logic [31:0] rddata;
    logic        misaligned_exc, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_rd = '0;

    lsu_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .funct3(funct3), .eff_addr(eff_addr), .store_data(store_data),
        .stall(stall), .rddata(rddata), .misaligned_exc(misaligned_exc),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One memory instruction; g/r = cycles of bus delay before gnt/rvalid.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input logic [31:0] rdat, input int g, input int r);
        int          size, off, req_cycles, rd_cycles, stall_n, req_hi;
        bit          write, tmo;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
        write = wr;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            default:        size = 4;
        endcase
        off = int'(addr % 4);
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; funct3 = f3; eff_addr = addr; store_data = sd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = rdat;
        #1;
        if ((addr % size) != 0) begin
            check("mis_stall", stall, 0);
            @(negedge clk);
            check("mis_exc", misaligned_exc, 1);
            check("mis_req", bus_req, 0);
            mem_rd = 1'b0; mem_wr = 1'b0;
            @(negedge clk);
            check("mis_exc_clr", misaligned_exc, 0);
            check("mis_req2", bus_req, 0);
            return;
        end
        check("idle_stall", stall, 1);
        exp_be = 4'b1111;
        exp_wd = sd;
        if (write) begin
            exp_be = '0;
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) exp_be[i] = 1'b1;
                exp_wd[8*i +: 8] = sd[8*(i % size) +: 8];
            end
        end
        stall_n = 1;
        req_hi = 0;
        tmo = (g >= T);
        req_cycles = tmo ? T : g + 1;
        rd_cycles = 0;
        for (int i = 0; i < req_cycles; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("req_addr", bus_addr, addr & 32'hFFFF_FFFC);
                check("req_we", bus_we, write);
                check("req_be", bus_be, exp_be);
                if (write) check("req_wdata", bus_wdata, exp_wd);
            end
            stall_n += stall;
            req_hi += bus_req;
            bus_gnt = (i == g);
        end
        if (!write && !tmo) begin
            tmo = (r >= T);
            rd_cycles = tmo ? T : r + 1;
            for (int i = 0; i < rd_cycles; i++) begin
                @(negedge clk);
                bus_gnt = 1'b0;
                stall_n += stall;
                req_hi += bus_req;
                bus_rvalid = (i == r);
            end
        end
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (tmo) exp_rd = '0;
        else if (!write) exp_rd = rdat >> (8 * off);
        else exp_rd = last_rd;
        last_rd = exp_rd;
        check("done_stall", stall, 0);
        check("done_err", bus_err, tmo);
        check("done_rddata", rddata, exp_rd);
        check("done_req", bus_req, 0);
        check("stall_cycles", stall_n, 1 + req_cycles + rd_cycles);
        check("req_cycles", req_hi, req_cycles);
        // mem_rd/mem_wr stay high across DONE; no new request may start.
        @(negedge clk);
        check("post_req", bus_req, 0);
        check("post_err", bus_err, 0);
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    // Spurious gnt/rvalid while idle must have no effect.
    task automatic idle_cycle();
        @(negedge clk);
        bus_gnt = 1'($urandom_range(0, 1));
        bus_rvalid = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_req", bus_req, 0);
        check("idle_stall2", stall, 0);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic reset_mid(input bit in_wait);
        @(negedge clk);
        mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; eff_addr = 32'h400;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        if (in_wait) begin
            bus_gnt = 1'b1;
            @(negedge clk);
            bus_gnt = 1'b0;
        end else begin
            check("rst_pre_req", bus_req, 1);
        end
        check("rst_pre_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        check("rst_req", bus_req, 0);
        check("rst_stall", stall, 0);
        mem_rd = 1'b0;
        @(negedge clk);
        check("rst_rddata", rddata, 0);
        check("rst_err", bus_err, 0);
        rst_n = 1'b1;
        last_rd = '0;
        @(negedge clk);
        check("rst_after_req", bus_req, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; funct3 = '0; eff_addr = '0; store_data = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_be", bus_be, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_rddata0", rddata, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_mis", misaligned_exc, 0);
        check("rst_stall0", stall, 0);
        rst_n = 1'b1;

        do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        do_access(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 0, 0);
        do_access(0, 1, 3'b001, 32'h302, 32'h1234_ABCD, 32'h0, 2, 0);
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
        do_access(0, 1, 3'b000, 32'h101, 32'h0000_00A5, 32'h0, 0, 0);
        do_access(1, 1, 3'b010, 32'h104, 32'hCAFE_F00D, 32'h0, 1, 0);
        do_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h8765_4321, 1, 3);
        do_access(1, 0, 3'b010, 32'h200, 32'h0, 32'h1111_2222, 0, 9);
        do_access(1, 0, 3'b001, 32'h202, 32'h0, 32'h5555_6666, 0, 0);
        do_access(0, 1, 3'b010, 32'h300, 32'h1, 32'h0, 7, 0);
        idle_cycle();
        reset_mid(0);
        reset_mid(1);
        do_access(1, 0, 3'b010, 32'h500, 32'h0, 32'h0BAD_F00D, 0, 1);

        for (int k = 0; k < 80; k++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = {20'h0, 12'($urandom())};
            do_access(kind != 1, kind != 0, 3'($urandom()), a, $urandom(), $urandom(),
                      $urandom_range(0, 5), $urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store unit bus controller, directly upstream of the register-file write-data select stage.
- Takes load/store requests from execute: ALU effective address, rs2 store data, funct3.
- Runs a req/gnt/rvalid transaction on the data bus and stalls the core until it completes.
- Delivers byte-lane-aligned read data (rddata), so the selected byte/halfword always sits at bit 0 for sign/zero extension downstream.
- Generates store byte enables, replicated write data, misalignment exceptions and bus-timeout errors.

Parameters:
ADDR_W, 32, bus/effective address width
DATA_W, 32, data width (fixed 32; other values unsupported)
TIMEOUT_CYCLES, 16, max cycles waiting for bus_gnt or bus_rvalid before abort (>=2)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
mem_rd  in  1  current instruction is a load
mem_wr  in  1  current instruction is a store
funct3  in  3  load/store width: 000 B, 001 H, 010 W, 100 BU, 101 HU
eff_addr  in  ADDR_W  effective address from ALU
store_data  in  DATA_W  rs2 value
stall  out  1  freeze PC/pipeline (combinational)
rddata  out  DATA_W  aligned load data, valid in DONE
misaligned_exc  out  1  1-cycle pulse: misaligned access, no bus cycle issued
bus_err  out  1  1-cycle pulse (in DONE): transaction timed out
bus_req  out  1  bus request
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address (eff_addr[1:0] forced to 00)
bus_be  out  4  byte enables
bus_wdata  out  DATA_W  write data
bus_gnt  in  1  request accepted (write complete / read address accepted)
bus_rvalid  in  1  read data valid
bus_rdata  in  DATA_W  read data

Behaviour:
Reset:
- All registered outputs are 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, rddata, bus_err, misaligned_exc.
- State is IDLE and the timeout counter is 0.
- rst_n assertion mid-transaction drops bus_req asynchronously and abandons the transaction. No completion or error is reported.

FSM states: IDLE, REQ, WAIT_RD, DONE.

IDLE:
- If mem_rd|mem_wr and the access is aligned: stall=1 (combinational). At the clock edge, register bus_addr, bus_we, bus_be, bus_wdata and offset=eff_addr[1:0]; set bus_req=1; go to REQ.
- Both mem_rd and mem_wr high: treat as a write.
- Misaligned access: misaligned_exc=1 for the next cycle, stall=0, no bus activity, stay in IDLE.
  - H/HU/SH misaligned when addr[0]=1.
  - W/SW misaligned when addr[1:0]!=00.
- funct3 values outside the list above: treat as W.

REQ:
- stall=1, bus_req held with stable address, we, be and wdata.
- On bus_gnt: deassert bus_req.
  - Write: go to DONE.
  - Read: go to WAIT_RD; counter=0.

WAIT_RD:
- stall=1.
- On bus_rvalid: rddata <= bus_rdata >> (8*offset), upper bits zero-filled. Go to DONE.

DONE:
- stall=0 for exactly one cycle, so the instruction retires.
- rddata holds until the next load capture.
- Next state is always IDLE. mem_rd/mem_wr still high during DONE must not start a new transaction.

Timeout:
- The counter increments each cycle in REQ and WAIT_RD and clears on state entry.
- Reaching TIMEOUT_CYCLES: deassert bus_req, rddata <= 0, bus_err=1 during DONE, go to DONE.

Store encoding:
- SB: be = 0001<<offset, wdata = {4{store_data[7:0]}}.
- SH: be = 0011<<offset, wdata = {2{store_data[15:0]}}.
- SW: be = 1111, wdata = store_data.
- For reads: be = 1111, bus_we=0.

Latency with zero-wait bus:
- Store: 3 cycles (IDLE, REQ+gnt, DONE).
- Load: 4 cycles (IDLE, REQ+gnt, WAIT_RD+rvalid, DONE).
- bus_gnt or bus_rvalid outside REQ/WAIT_RD: ignored.

Test Plan:
- LW addr 0x100, bus_rdata 0xDEADBEEF, gnt in REQ, rvalid next cycle -> stall high 3 cycles; DONE: rddata 0xDEADBEEF, bus_addr 0x100, be 1111.
- LBU addr 0x203, bus_rdata 0x80FF_1234 -> bus_addr 0x200; rddata 0x0000_0080.
- SH addr 0x302, store_data 0x1234_ABCD, gnt after 2 wait cycles -> be 1100, wdata 0xABCD_ABCD, we=1, stall released in DONE, 5 cycles total.
- LW addr 0x101 -> misaligned_exc one cycle, bus_req never asserted, stall 0; SB addr 0x101 -> legal, be 0010.
- TIMEOUT_CYCLES=4, read, rvalid never arrives -> bus_req drops, bus_err pulse in DONE, rddata 0, stall released.
- rst_n low while in WAIT_RD -> bus_req/stall 0 immediately; after release: IDLE, next LW completes normally.
